// File: rtl/upward_counter_pkg.sv
// Shared constants and the next-state helper for the modulo up-counter and
// the time-of-day chains built from it.
package upward_counter_pkg;

    localparam int unsigned DEFAULT_WIDTH = 6;

    // Terminal values for a seconds/minutes/hours chain.
    localparam int unsigned SEC_LIMIT  = 59;
    localparam int unsigned MIN_LIMIT  = 59;
    localparam int unsigned HOUR_LIMIT = 23;

    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_WRAP = 2'd1,
        CNT_INC  = 2'd2
    } cnt_op_e;

    // Non-reset action for one edge. The wrap test is >=, so a limit lowered
    // below the current count still brings the counter back to 0.
    function automatic cnt_op_e cnt_op(input logic en, input logic at_limit);
        if (!en)
            return CNT_HOLD;
        else if (at_limit)
            return CNT_WRAP;
        else
            return CNT_INC;
    endfunction

endpackage

// File: rtl/upward_counter.sv
// Synchronous modulo up-counter: counts 0..limit on enabled edges, then wraps.
// tc is a combinational carry meant to enable the next stage of a chain.
module upward_counter
    import upward_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    // Declaration init keeps an un-reset counter at 0 rather than X.
    logic [WIDTH-1:0] count_q = '0;
    logic [WIDTH-1:0] count_d;
    logic             at_limit;
    cnt_op_e          op;

    assign at_limit = (count_q >= limit);
    assign op       = cnt_op(en, at_limit);

    always_comb begin
        count_d = count_q;
        unique case (op)
            CNT_HOLD: count_d = count_q;
            CNT_WRAP: count_d = '0;
            CNT_INC:  count_d = count_q + WIDTH'(1);
            default:  count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count = count_q;
    assign tc    = en & at_limit;

`ifndef SYNTHESIS
    logic             chk_vld_q  = 1'b0;
    logic [WIDTH-1:0] lim_prev_q = '0;

    always_ff @(posedge clk) begin
        chk_vld_q  <= reset | en;
        lim_prev_q <= limit;
    end

    // Once the counter has been reset or stepped against a limit that has not
    // moved since, it must sit at or below that limit.
    always @(negedge clk) begin
        if (chk_vld_q && (limit == lim_prev_q))
            assert (count_q <= limit)
            else $error("upward_counter: count %0d above limit %0d", count_q, limit);
        assert (tc == (en & (count_q >= limit)))
        else $error("upward_counter: tc inconsistent with en/count/limit");
    end
`endif

endmodule

// File: tb/tb_upward_counter.sv
// Directed bench: single 6-bit counter, a 4-bit roll-over counter and a
// seconds/minutes/hours chain, with hand-derived expected values.
module tb_upward_counter;

    logic       clk = 1'b0;
    logic       reset, en;
    logic [5:0] limit, count;
    logic       tc;

    logic       r4, e4;
    logic [3:0] l4, c4;
    logic       t4;

    logic       crst, cen;
    logic [5:0] ls, lm, lh, cs, cm, ch;
    logic       ts, tm, th;
    logic       m_en, h_en;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign m_en = cen & ts;
    assign h_en = cen & tm & ts;

    upward_counter #(.WIDTH(6)) dut (
        .clk(clk), .reset(reset), .en(en), .limit(limit), .count(count), .tc(tc));
    upward_counter #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(r4), .en(e4), .limit(l4), .count(c4), .tc(t4));
    upward_counter #(.WIDTH(6)) u_ss (
        .clk(clk), .reset(crst), .en(cen), .limit(ls), .count(cs), .tc(ts));
    upward_counter #(.WIDTH(6)) u_mm (
        .clk(clk), .reset(crst), .en(m_en), .limit(lm), .count(cm), .tc(tm));
    upward_counter #(.WIDTH(6)) u_hh (
        .clk(clk), .reset(crst), .en(h_en), .limit(lh), .count(ch), .tc(th));

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input int exp);
        checks++;
        assert (obs === 8'(exp))
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; limit = 6'd59;
        r4 = 1'b0; e4 = 1'b0; l4 = 4'd15;
        crst = 1'b0; cen = 1'b0; ls = 6'd59; lm = 6'd59; lh = 6'd23;
        #1;
        chk("powerup_count", 8'(count), 0);
        chk("powerup_c4", 8'(c4), 0);
        chk("powerup_tc", 8'(tc), 0);

        // 1. reset held two edges with en high
        reset = 1'b1; en = 1'b1;
        tick(1); chk("reset_edge1", 8'(count), 0);
        tick(1); chk("reset_edge2", 8'(count), 0);

        // 2. full mod-60 sequence, tc only while count is 59
        reset = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            chk("seq_tc", 8'(tc), (i == 60) ? 1 : 0);
            tick(1);
            chk("seq_count", 8'(count), i % 60);
        end

        // 3. enable gating
        en = 1'b1; tick(1); chk("en_on1", 8'(count), 1);
        en = 1'b0; #1; chk("en_off_tc", 8'(tc), 0);
        tick(1); chk("en_off1", 8'(count), 1);
        en = 1'b1; tick(1); chk("en_on2", 8'(count), 2);
        en = 1'b0; tick(1); chk("en_off2", 8'(count), 2);

        // 4. limit lowered below count, then mod-24
        en = 1'b1; tick(38); chk("reach40", 8'(count), 40);
        limit = 6'd23; #1; chk("lowered_tc", 8'(tc), 1);
        tick(1); chk("lowered_wrap", 8'(count), 0);
        tick(23); chk("mod24_top", 8'(count), 23);
        tick(1); chk("mod24_wrap", 8'(count), 0);

        // limit raised mid-count
        tick(10); chk("mid10", 8'(count), 10);
        limit = 6'd30;
        tick(20); chk("raised_top", 8'(count), 30);
        tick(1); chk("raised_wrap", 8'(count), 0);

        // 5. limit = 0
        limit = 6'd0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("lim0_count", 8'(count), 0);
            chk("lim0_tc", 8'(tc), 1);
        end
        en = 1'b0; #1; chk("lim0_tc_en0", 8'(tc), 0);

        // reset mid-sequence with en high: reset wins, tc reflects pre-edge
        limit = 6'd59; en = 1'b1;
        tick(5); chk("pre_rst5", 8'(count), 5);
        reset = 1'b1; #1; chk("rst_en_tc", 8'(tc), 0);
        tick(1); chk("rst_en_count", 8'(count), 0);
        reset = 1'b0; tick(1); chk("rst_resume", 8'(count), 1);
        tick(58); chk("pre_rst59", 8'(count), 59);
        reset = 1'b1; #1; chk("rst59_tc", 8'(tc), 1);
        tick(1); chk("rst59_count", 8'(count), 0);
        reset = 1'b0; en = 1'b0;

        // WIDTH=4 full roll-over
        r4 = 1'b1; tick(1); r4 = 1'b0; e4 = 1'b1;
        tick(15); chk("w4_top", 8'(c4), 15);
        chk("w4_tc", 8'(t4), 1);
        tick(1); chk("w4_wrap", 8'(c4), 0);
        e4 = 1'b0;

        // 6. chain: load 23:59:59 using zero limits to force carries
        crst = 1'b1; tick(1); crst = 1'b0; cen = 1'b1;
        ls = 6'd0; lm = 6'd0; lh = 6'd23;
        tick(23);
        lm = 6'd59; tick(59);
        ls = 6'd59; tick(59);
        chk("chain_ss59", 8'(cs), 59);
        chk("chain_mm59", 8'(cm), 59);
        chk("chain_hh23", 8'(ch), 23);
        chk("chain_hh_tc", 8'(th), 1);
        tick(1);
        chk("chain_ss0", 8'(cs), 0);
        chk("chain_mm0", 8'(cm), 0);
        chk("chain_hh0", 8'(ch), 0);

        // chain reset at 12:34:56
        ls = 6'd0; lm = 6'd0; tick(12);
        lm = 6'd59; tick(34);
        ls = 6'd59; tick(56);
        chk("chain_hh12", 8'(ch), 12);
        chk("chain_mm34", 8'(cm), 34);
        chk("chain_ss56", 8'(cs), 56);
        crst = 1'b1; tick(1); crst = 1'b0;
        chk("chain_rst_ss", 8'(cs), 0);
        chk("chain_rst_mm", 8'(cm), 0);
        chk("chain_rst_hh", 8'(ch), 0);
        tick(1); chk("chain_resume", 8'(cs), 1);
        cen = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
